// File: rtl/conv_pkg.sv
// Shared state encoding and sizing/saturation helpers for the conv2 MAC streaming engine.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

  // Saturation works on a sign-extended copy, so any ACC_W up to SAT_W is covered.
  localparam int SAT_W = 64;

  function automatic int conv_out_size(input int size, input int ksize, input int stride);
    return (size - ksize) / stride + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_to_width(input logic signed [SAT_W-1:0] acc,
                                                          input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Single signed MAC with full-precision product, clear/enable control and saturated readout.
module conv_mac_sat
  import conv_pkg::*;
#(
  parameter int WIDTH_BIT = 16,
  parameter int ACC_W     = 36
)(
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic signed [WIDTH_BIT-1:0] i_a,
  input  logic signed [WIDTH_BIT-1:0] i_b,
  output logic signed [WIDTH_BIT-1:0] o_sat
);

  logic signed [2*WIDTH_BIT-1:0] w_prod;
  logic signed [ACC_W-1:0]       r_acc;

  assign w_prod = (2*WIDTH_BIT)'(i_a) * (2*WIDTH_BIT)'(i_b);

  // Clear wins over enable so a handshake never leaks a stale term into the next window.
  always_ff @(posedge clock) begin
    if (!nreset)    r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc + ACC_W'(w_prod);
  end

  assign o_sat = WIDTH_BIT'(sat_to_width(SAT_W'(r_acc), WIDTH_BIT));

endmodule

// File: rtl/conv2_mac_stream.sv
// Multi-channel strided valid 2-D convolution on one time-multiplexed MAC,
// streaming saturated results over valid/ready and mirroring them into a result plane.
module conv2_mac_stream
  import conv_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16,
  parameter int CHANNELS  = 1,
  parameter int STRIDE    = 1,
  parameter int ACC_W     = 2*WIDTH_BIT + $clog2(CHANNELS*SIZEKer*SIZEKer+1),
  localparam int OUT      = conv_out_size(SIZE, SIZEKer, STRIDE),
  localparam int OW       = $clog2(OUT+1)
)(
  input  logic                                                      clock,
  input  logic                                                      nreset,
  input  logic                                                      start,
  input  logic [CHANNELS-1:0][SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]       inpMatrixI,
  input  logic [CHANNELS-1:0][SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] inpKernel,
  output logic                                                      busy,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic signed [WIDTH_BIT-1:0]                               out_data,
  output logic [OW-1:0]                                             out_row,
  output logic [OW-1:0]                                             out_col,
  output logic                                                      done,
  output logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]                    convIxKernelOut
);

  localparam int RW  = (SIZE > 1)     ? $clog2(SIZE)     : 1;
  localparam int KW  = (SIZEKer > 1)  ? $clog2(SIZEKer)  : 1;
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OIW = (OUT > 1)      ? $clog2(OUT)      : 1;

  state_t r_state, w_next;

  logic [CHANNELS-1:0][SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]       r_img;
  logic [CHANNELS-1:0][SIZEKer-1:0][SIZEKer-1:0][WIDTH_BIT-1:0] r_ker;
  logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]                       r_conv;

  logic [OW-1:0] r_orow, r_ocol;
  logic [CW-1:0] r_ch;
  logic [KW-1:0] r_kr, r_kc;

  logic [RW-1:0]                w_row, w_col;
  logic signed [WIDTH_BIT-1:0]  w_pix, w_coef, w_sat;
  logic                         w_last_term, w_last_pix, w_hs, w_clr, w_en;

  // Window addressing into the snapshots; only the snapshots feed the MAC.
  assign w_row  = RW'(r_orow) * RW'(STRIDE) + RW'(r_kr);
  assign w_col  = RW'(r_ocol) * RW'(STRIDE) + RW'(r_kc);
  assign w_pix  = r_img[r_ch][w_row][w_col];
  assign w_coef = r_ker[r_ch][r_kr][r_kc];

  assign w_last_term = (r_ch == CW'(CHANNELS-1)) && (r_kr == KW'(SIZEKer-1)) &&
                       (r_kc == KW'(SIZEKer-1));
  assign w_last_pix  = (r_orow == OW'(OUT-1)) && (r_ocol == OW'(OUT-1));
  assign w_hs        = (r_state == WRITE) && out_ready;
  assign w_clr       = (r_state == LOAD) || w_hs;
  assign w_en        = (r_state == MAC);

  conv_mac_sat #(
    .WIDTH_BIT (WIDTH_BIT),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clock  (clock),
    .nreset (nreset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_a    (w_pix),
    .i_b    (w_coef),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clock) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = LOAD;
      end
      LOAD:  w_next = MAC;
      MAC:   if (w_last_term) w_next = WRITE;
      WRITE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = w_last_pix ? DONE : MAC;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_img  <= '0;
      r_ker  <= '0;
      r_conv <= '0;
      r_orow <= '0;
      r_ocol <= '0;
      r_ch   <= '0;
      r_kr   <= '0;
      r_kc   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_img <= inpMatrixI;
          r_ker <= inpKernel;
        end
        LOAD: begin
          r_conv <= '0;
          r_orow <= '0;
          r_ocol <= '0;
          r_ch   <= '0;
          r_kr   <= '0;
          r_kc   <= '0;
        end
        MAC: begin
          // kc fastest, then kr, then ch; all wrap to 0 after the last term.
          if (r_kc == KW'(SIZEKer-1)) begin
            r_kc <= '0;
            if (r_kr == KW'(SIZEKer-1)) begin
              r_kr <= '0;
              r_ch <= (r_ch == CW'(CHANNELS-1)) ? '0 : r_ch + 1'b1;
            end else begin
              r_kr <= r_kr + 1'b1;
            end
          end else begin
            r_kc <= r_kc + 1'b1;
          end
        end
        WRITE: if (out_ready) begin
          r_conv[OIW'(r_orow)][OIW'(r_ocol)] <= w_sat;
          if (r_ocol == OW'(OUT-1)) begin
            r_ocol <= '0;
            r_orow <= r_orow + 1'b1;
          end else begin
            r_ocol <= r_ocol + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data        = w_sat;
  assign out_row         = r_orow;
  assign out_col         = r_ocol;
  assign convIxKernelOut = r_conv;

endmodule

// File: tb/tb_conv2_mac_stream.sv
// Directed bench for conv2_mac_stream: default, strided and two-channel instances sharing one clock.
module tb_conv2_mac_stream;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic nreset, start, out_ready;
  int   sel, total, bad, cyc;
  int   q_data[$], q_row[$], q_col[$];

  logic [0:0][7:0][7:0][15:0] img0, img1;
  logic [0:0][2:0][2:0][15:0] ker0, ker1;
  logic [1:0][7:0][7:0][15:0] img2;
  logic [1:0][2:0][2:0][15:0] ker2;

  logic busy0, busy1, busy2, valid0, valid1, valid2, done0, done1, done2;
  logic signed [15:0] data0, data1, data2;
  logic [2:0] row0, col0, row2, col2;
  logic [1:0] row1, col1;
  logic [5:0][5:0][15:0] plane0, plane2;
  logic [2:0][2:0][15:0] plane1;

  logic v_valid, v_done, v_busy;
  int   v_data, v_row, v_col;

  conv2_mac_stream #(.SIZE(8), .SIZEKer(3), .WIDTH_BIT(16), .CHANNELS(1), .STRIDE(1)) u_dut0 (
    .clock(clock), .nreset(nreset), .start(start && (sel == 0)),
    .inpMatrixI(img0), .inpKernel(ker0), .busy(busy0), .out_valid(valid0),
    .out_ready(out_ready), .out_data(data0), .out_row(row0), .out_col(col0),
    .done(done0), .convIxKernelOut(plane0));

  conv2_mac_stream #(.SIZE(8), .SIZEKer(3), .WIDTH_BIT(16), .CHANNELS(1), .STRIDE(2)) u_dut1 (
    .clock(clock), .nreset(nreset), .start(start && (sel == 1)),
    .inpMatrixI(img1), .inpKernel(ker1), .busy(busy1), .out_valid(valid1),
    .out_ready(out_ready), .out_data(data1), .out_row(row1), .out_col(col1),
    .done(done1), .convIxKernelOut(plane1));

  conv2_mac_stream #(.SIZE(8), .SIZEKer(3), .WIDTH_BIT(16), .CHANNELS(2), .STRIDE(1)) u_dut2 (
    .clock(clock), .nreset(nreset), .start(start && (sel == 2)),
    .inpMatrixI(img2), .inpKernel(ker2), .busy(busy2), .out_valid(valid2),
    .out_ready(out_ready), .out_data(data2), .out_row(row2), .out_col(col2),
    .done(done2), .convIxKernelOut(plane2));

  // View of whichever instance the current step is driving.
  always_comb begin
    v_valid = valid0; v_done = done0; v_busy = busy0;
    v_data  = int'(data0); v_row = int'(row0); v_col = int'(col0);
    if (sel == 1) begin
      v_valid = valid1; v_done = done1; v_busy = busy1;
      v_data  = int'(data1); v_row = int'(row1); v_col = int'(col1);
    end else if (sel == 2) begin
      v_valid = valid2; v_done = done2; v_busy = busy2;
      v_data  = int'(data2); v_row = int'(row2); v_col = int'(col2);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept, then run with out_ready as set, logging every handshake; cyc = edges from accept to done.
  task automatic run(input int budget, input int busy_poke);
    q_data.delete(); q_row.delete(); q_col.delete();
    if (v_busy) begin @(posedge clock); #1; end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    while (!v_done && cyc < budget) begin
      start = (cyc == busy_poke);
      if (v_valid && out_ready) begin
        q_data.push_back(v_data); q_row.push_back(v_row); q_col.push_back(v_col);
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", int'(v_done), 1);
  endtask

  task automatic check_stream(input string tag, input int n, input int outsz, input int exp);
    chk({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < q_data.size() && i < n; i++) begin
      chk({tag, "_data"}, q_data[i], exp);
      chk({tag, "_row"},  q_row[i],  i / outsz);
      chk({tag, "_col"},  q_col[i],  i % outsz);
    end
  endtask

  task automatic fill0(input logic [15:0] pix, input logic [15:0] coef);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img0[0][r][c] = pix;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) ker0[0][r][c] = coef;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  int'(v_busy),  0);
    chk({tag, "_valid"}, int'(v_valid), 0);
    chk({tag, "_done"},  int'(v_done),  0);
    chk({tag, "_data"},  v_data, 0);
    chk({tag, "_row"},   v_row,  0);
    chk({tag, "_col"},   v_col,  0);
    chk({tag, "_plane"}, int'(plane0 == '0), 1);
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; cyc = 0;
    start = 1'b0; out_ready = 1'b1; nreset = 1'b0;
    fill0(16'd1, 16'd1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        img1[0][r][c] = 16'd2;
        img2[0][r][c] = 16'd1;
        img2[1][r][c] = 16'd1;
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ker1[0][r][c] = 16'd1;
        ker2[0][r][c] = 16'd1;
        ker2[1][r][c] = 16'hFFFE;
      end

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_idle_outputs("reset");
    nreset = 1'b1;
    @(posedge clock); #1;

    // All ones, start poked mid-run, start held in the DONE cycle
    run(2000, 50);
    chk("ones_done_cycle", cyc, 361);
    check_stream("ones", 36, 6, 9);
    chk("ones_plane_55", int'($signed(plane0[5][5])), 9);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("done_one_cycle", int'(v_done), 0);
    chk("start_in_done_ignored", int'(v_busy), 0);
    chk("plane_held_after_done", int'($signed(plane0[2][4])), 9);

    // Identity-centre kernel with backpressure on the first result
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img0[0][r][c] = 16'(r * 8 + c);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) ker0[0][r][c] = (r == 1 && c == 1) ? 16'd1 : 16'd0;
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    // Inputs changed after accept must not reach the engine.
    fill0(16'd5, 16'd5);
    cyc = 0;
    while (!v_valid && cyc < 100) begin @(posedge clock); #1; cyc++; end
    chk("bp_first_valid_cycle", cyc, 10);
    repeat (5) begin
      chk("bp_valid", int'(v_valid), 1);
      chk("bp_data",  v_data, 9);
      chk("bp_row",   v_row,  0);
      chk("bp_col",   v_col,  0);
      @(posedge clock); #1;
    end
    chk("bp_still_valid", int'(v_valid), 1);
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_valid_drop", int'(v_valid), 0);
    chk("bp_plane_00", int'($signed(plane0[0][0])), 9);
    cyc = 0;
    while (!v_valid && cyc < 100) begin @(posedge clock); #1; cyc++; end
    chk("bp_second_col",  v_col,  1);
    chk("bp_second_row",  v_row,  0);
    chk("bp_second_data", v_data, 10);
    cyc = 0;
    while (!v_done && cyc < 1000) begin @(posedge clock); #1; cyc++; end
    chk("ident_done", int'(v_done), 1);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        chk("ident_plane", int'($signed(plane0[i][j])), (i + 1) * 8 + (j + 1));

    // Saturation, both rails
    fill0(16'h7FFF, 16'h7FFF);
    run(2000, -1);
    chk("sat_pos_first", (q_data.size() > 0) ? q_data[0] : 0, 32767);
    chk("sat_pos_plane", int'($signed(plane0[3][2])), 32767);
    fill0(16'h7FFF, 16'h8001);
    run(2000, -1);
    chk("sat_neg_first", (q_data.size() > 0) ? q_data[0] : 0, -32768);
    chk("sat_neg_plane", int'($signed(plane0[1][4])), -32768);

    // Reset mid-operation, then a clean run
    fill0(16'd1, 16'd1);
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (99) @(posedge clock);
    #1;
    chk("midrun_busy", int'(v_busy), 1);
    nreset = 1'b0;
    @(posedge clock); #1;
    chk_idle_outputs("abort");
    nreset = 1'b1;
    @(posedge clock); #1;
    run(2000, -1);
    chk("rerun_done_cycle", cyc, 361);
    check_stream("rerun", 36, 6, 9);

    // STRIDE=2: OUT=3, all 2 * all 1
    sel = 1;
    run(500, -1);
    chk("stride_done_cycle", cyc, 91);
    check_stream("stride", 9, 3, 18);
    chk("stride_plane_22", int'($signed(plane1[2][2])), 18);

    // CHANNELS=2: 9*1 + 9*(-2)
    sel = 2;
    run(2000, -1);
    chk("chan_done_cycle", cyc, 685);
    check_stream("chan", 36, 6, -9);
    chk("chan_plane_05", int'($signed(plane2[0][5])), -9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
